wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage; the writer side of the register-file write port that the decode stage consumes.
//  Takes retiring instructions from MEM and returns variable-latency data-memory load responses.
//  Aligns and extends load data, then drives a one-cycle register write pulse.
//  Stalls upstream while a load is outstanding and flags misaligned, illegal and timed-out loads.
// PARAMETERS
//  DATA_WIDTH    32  datapath width (must be 32)
//  LOAD_TIMEOUT  16  max cycles spent in WAIT_LOAD before abort (>=2)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-low
//  mem_valid_i    in   1   MEM presents a retiring instruction this cycle
//  mem_reg_write  in   1   instruction writes rd
//  mem_rd_sel     in   1   1 = load data, 0 = ALU result
//  mem_rd_addr    in   5   destination register
//  mem_funct3     in   3   load size/sign (000 LB,001 LH,010 LW,100 LBU,101 LHU)
//  mem_alu_result in   32  ALU result; load byte address when mem_rd_sel=1
//  dm_rvalid      in   1   data-memory read response valid
//  dm_rdata       in   32  data-memory read word (word-aligned)
//  stall_o        out  1   upstream must hold MEM; instruction not accepted
//  reg_write      out  1   register-file write enable (1-cycle pulse)
//  reg_rd_addr    out  5   register-file write address
//  reg_rd_data    out  32  register-file write data
//  ld_misalign_o  out  1   1-cycle pulse: misaligned load dropped
//  ld_illegal_o   out  1   1-cycle pulse: illegal load funct3 dropped
//  ld_timeout_o   out  1   1-cycle pulse: load response never arrived
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, timeout counter=0, all outputs 0.
//  Accept: mem_valid_i && !stall_o. stall_o = (state==WAIT_LOAD), driven from a register.
//  Non-load accepted in IDLE: the next cycle reg_write = mem_reg_write && rd!=0.
//  With that pulse, reg_rd_addr=rd and reg_rd_data=mem_alu_result. Latency 1.
//  State stays IDLE, so back-to-back ALU instructions retire one per cycle.
//  Load accepted in IDLE: check misalignment and funct3 first.
//   - Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
//     Next cycle ld_misalign_o=1, no write, stay IDLE.
//   - Illegal funct3 (011,110,111): next cycle ld_illegal_o=1, no write, stay IDLE.
//     Misalignment checking applies only to legal encodings.
//   - Otherwise latch rd, funct3, addr[1:0] and reg_write; go to WAIT_LOAD with counter=0.
//  WAIT_LOAD, each cycle:
//   - dm_rvalid=1: extract and extend the data. Next cycle reg_write pulses (if rd!=0 and reg_write latched).
//     Go to IDLE.
//   - Else counter++. When the counter reaches LOAD_TIMEOUT-1: next cycle ld_timeout_o=1, no write, go to IDLE.
//   - If dm_rvalid and the timeout coincide, dm_rvalid wins.
//  Extraction: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW takes the whole word.
//   LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
//  dm_rvalid while IDLE: ignored, no output change.
//  rd=0: never asserts reg_write. Extraction still proceeds and timeout/error pulses still fire.
//  reg_rd_addr/reg_rd_data hold their last written value when reg_write=0.
//  Reset mid-load: aborts immediately and leaves no pending write; a later dm_rvalid is ignored.
//  No combinational path from any input to any output.
// STRUCTURE
//  wb_pkg: funct3 load encodings (F3_LB..F3_LHU), wb_state_t enum {IDLE, WAIT_LOAD}.
//  Sub-module wb_load_ext (combinational): funct3 + addr[1:0] + rdata -> extended 32-bit value.
//  Top holds the FSM, the timeout counter ($clog2(LOAD_TIMEOUT) bits) and the output registers.
// TESTING
//  1 ALU: rd=5, alu=0xDEADBEEF, rd_sel=0 -> cycle+1 reg_write=1, addr 5, data 0xDEADBEEF; stall_o never 1.
//  2 LB: addr=0x1003, rdata=0x80FF1234 after 3 cycles -> stall_o=1 for 3 cycles; write 0xFFFFFF80.
//    Same with LBU -> 0x00000080.
//  3 LH at addr 0x1002, rdata=0x8001_7FFF -> 0xFFFF8001.
//    LHU at 0x1001 -> ld_misalign_o pulse, no write.
//  4 LW, no dm_rvalid, LOAD_TIMEOUT=16 -> ld_timeout_o after 16 WAIT cycles, no write, stall_o drops.
//    rvalid on the final cycle -> write instead.
//  5 LW to rd=0 with rvalid, then funct3=011 -> no reg_write; ld_illegal_o pulses once.
//  6 Reset in WAIT_LOAD, then dm_rvalid -> all outputs 0, no write; a following ALU op retires normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings, FSM states
// and the load legality/alignment rules used when a load is accepted.
package wb_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } wb_state_t;

   function automatic logic f3_legal(input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
         default:                             ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte loads can never be misaligned; only meaningful for legal encodings.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      case (f3)
         F3_LH, F3_LHU: mis = off[0];
         F3_LW:         mis = (off != 2'b00);
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/wb_if.sv
// Bundle of the MEM retire bus, data-memory response, register-file write port
// and load error flags seen by the writeback stage.
interface wb_if;
   import wb_pkg::*;

   logic            mem_valid_i;
   logic            mem_reg_write;
   logic            mem_rd_sel;
   logic [4:0]      mem_rd_addr;
   logic [2:0]      mem_funct3;
   logic [XLEN-1:0] mem_alu_result;
   logic            dm_rvalid;
   logic [XLEN-1:0] dm_rdata;
   logic            stall_o;
   logic            reg_write;
   logic [4:0]      reg_rd_addr;
   logic [XLEN-1:0] reg_rd_data;
   logic            ld_misalign_o;
   logic            ld_illegal_o;
   logic            ld_timeout_o;

   modport master (
      output mem_valid_i, mem_reg_write, mem_rd_sel, mem_rd_addr, mem_funct3,
             mem_alu_result, dm_rvalid, dm_rdata,
      input  stall_o, reg_write, reg_rd_addr, reg_rd_data,
             ld_misalign_o, ld_illegal_o, ld_timeout_o
   );

   modport slave (
      input  mem_valid_i, mem_reg_write, mem_rd_sel, mem_rd_addr, mem_funct3,
             mem_alu_result, dm_rvalid, dm_rdata,
      output stall_o, reg_write, reg_rd_addr, reg_rd_data,
             ld_misalign_o, ld_illegal_o, ld_timeout_o
   );

endinterface

// File: rtl/wb_load_ext.sv
// Load data alignment: picks the byte/half/word out of a word-aligned read and
// sign- or zero-extends it according to funct3.
module wb_load_ext
   import wb_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      byte_off,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] ext
);

   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   always_comb begin
      byte_s = rdata[{byte_off, 3'b000} +: 8];
      half_s = byte_off[1] ? rdata[31:16] : rdata[15:0];
      ext    = rdata;
      case (funct3)
         F3_LB:   ext = XLEN'(byte_s);
         F3_LBU:  ext = XLEN'($unsigned(byte_s));
         F3_LH:   ext = XLEN'(half_s);
         F3_LHU:  ext = XLEN'($unsigned(half_s));
         default: ext = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results in one cycle, holds MEM while a load is
// outstanding, and writes aligned/extended load data or flags load errors.
module wb_stage
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH   = XLEN,
   parameter int LOAD_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   wb_if.slave  bus
);

   localparam int CNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

   wb_state_t             state;
   logic                  stall_q;
   logic [CNT_W-1:0]      cnt_p1;
   logic                  ld_we_p1;
   logic [4:0]            ld_rd_p1;
   logic [2:0]            ld_f3_p1;
   logic [1:0]            ld_off_p1;
   logic [XLEN-1:0]       ext_p1;
   logic                  reg_write_q;
   logic [4:0]            reg_rd_addr_q;
   logic [DATA_WIDTH-1:0] reg_rd_data_q;
   logic                  misalign_q;
   logic                  illegal_q;
   logic                  timeout_q;

   // p0: decode of the instruction offered by MEM
   logic accept_p0;
   logic we_p0;
   logic legal_p0;
   logic misalign_p0;
   logic load_start_p0;

   assign accept_p0     = bus.mem_valid_i && !stall_q;
   assign we_p0         = bus.mem_reg_write && (bus.mem_rd_addr != 5'd0);
   assign legal_p0      = f3_legal(bus.mem_funct3);
   assign misalign_p0   = f3_misaligned(bus.mem_funct3, bus.mem_alu_result[1:0]);
   assign load_start_p0 = accept_p0 && bus.mem_rd_sel && legal_p0 && !misalign_p0;

   // p1: outstanding-load context, consumed when the response returns
   always_ff @(posedge clk) begin
      if (load_start_p0) begin
         ld_rd_p1  <= bus.mem_rd_addr;
         ld_f3_p1  <= bus.mem_funct3;
         ld_off_p1 <= bus.mem_alu_result[1:0];
      end
   end

   wb_load_ext u_load_ext (
      .funct3   (ld_f3_p1),
      .byte_off (ld_off_p1),
      .rdata    (bus.dm_rdata),
      .ext      (ext_p1)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         stall_q       <= 1'b0;
         cnt_p1        <= '0;
         ld_we_p1      <= 1'b0;
         reg_write_q   <= 1'b0;
         reg_rd_addr_q <= '0;
         reg_rd_data_q <= '0;
         misalign_q    <= 1'b0;
         illegal_q     <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         reg_write_q <= 1'b0;
         misalign_q  <= 1'b0;
         illegal_q   <= 1'b0;
         timeout_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_p0) begin
                  if (!bus.mem_rd_sel) begin
                     if (we_p0) begin
                        reg_write_q   <= 1'b1;
                        reg_rd_addr_q <= bus.mem_rd_addr;
                        reg_rd_data_q <= bus.mem_alu_result;
                     end
                  end else if (!legal_p0) begin
                     illegal_q <= 1'b1;
                  end else if (misalign_p0) begin
                     misalign_q <= 1'b1;
                  end else begin
                     ld_we_p1 <= we_p0;
                     cnt_p1   <= '0;
                     state    <= WAIT_LOAD;
                     stall_q  <= 1'b1;
                  end
               end
            end
            WAIT_LOAD: begin
               // A response in the last allowed cycle still wins over the timeout.
               if (bus.dm_rvalid) begin
                  if (ld_we_p1) begin
                     reg_write_q   <= 1'b1;
                     reg_rd_addr_q <= ld_rd_p1;
                     reg_rd_data_q <= ext_p1;
                  end
                  state   <= IDLE;
                  stall_q <= 1'b0;
               end else if (cnt_p1 == CNT_LAST) begin
                  timeout_q <= 1'b1;
                  state     <= IDLE;
                  stall_q   <= 1'b0;
               end else begin
                  cnt_p1 <= cnt_p1 + CNT_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               stall_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.stall_o       = stall_q;
   assign bus.reg_write     = reg_write_q;
   assign bus.reg_rd_addr   = reg_rd_addr_q;
   assign bus.reg_rd_data   = reg_rd_data_q;
   assign bus.ld_misalign_o = misalign_q;
   assign bus.ld_illegal_o  = illegal_q;
   assign bus.ld_timeout_o  = timeout_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: drivers push expected writeback events from a
// behavioural model, an independent monitor pops and compares observed pulses.
module tb_wb_stage;
   import wb_pkg::*;

   localparam int LT = 16;

   localparam logic [3:0] K_WR  = 4'b1000;
   localparam logic [3:0] K_MIS = 4'b0100;
   localparam logic [3:0] K_ILL = 4'b0010;
   localparam logic [3:0] K_TO  = 4'b0001;

   typedef struct {
      logic [3:0]  kind;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_if bus ();

   wb_stage #(.DATA_WIDTH(32), .LOAD_TIMEOUT(LT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [4:0]  last_addr;
   logic [31:0] last_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic expect_ev(input logic [3:0] kind, input logic [4:0] addr, input logic [31:0] data);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
   endtask

   function automatic bit is_legal(input int f3);
      return (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
   endfunction

   function automatic bit is_mis(input int f3, input int a);
      if (f3 == 1 || f3 == 5) return (a % 2) != 0;
      if (f3 == 2)            return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input int f3, input int a, input logic [31:0] word);
      int unsigned w;
      int unsigned v;
      w = word;
      v = w;
      case (f3)
         0: begin v = (w >> (8 * a)) % 256;          if (v >= 128)   v = v + 32'hFFFF_FF00; end
         4: v = (w >> (8 * a)) % 256;
         1: begin v = (w >> (16 * (a / 2))) % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
         5: v = (w >> (16 * (a / 2))) % 65536;
         default: v = w;
      endcase
      return v;
   endfunction

   always @(negedge clk) begin
      logic [3:0] act;
      exp_t       e;
      if (rst !== 1'b1) begin
         last_addr = '0;
         last_data = '0;
      end else begin
         act = {bus.reg_write, bus.ld_misalign_o, bus.ld_illegal_o, bus.ld_timeout_o};
         if (act != 4'b0000) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", 32'(act), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("event_kind", 32'(act), 32'(e.kind));
               if (e.kind == K_WR) begin
                  chk("wr_addr", 32'(bus.reg_rd_addr), 32'(e.addr));
                  chk("wr_data", bus.reg_rd_data, e.data);
                  last_addr = e.addr;
                  last_data = e.data;
               end
            end
         end else begin
            chk("hold_addr", 32'(bus.reg_rd_addr), 32'(last_addr));
            chk("hold_data", bus.reg_rd_data, last_data);
         end
      end
   end

   task automatic reset_check(input string tag);
      chk({tag, "_reg_write"}, 32'(bus.reg_write), 32'd0);
      chk({tag, "_rd_addr"}, 32'(bus.reg_rd_addr), 32'd0);
      chk({tag, "_rd_data"}, bus.reg_rd_data, 32'd0);
      chk({tag, "_misalign"}, 32'(bus.ld_misalign_o), 32'd0);
      chk({tag, "_illegal"}, 32'(bus.ld_illegal_o), 32'd0);
      chk({tag, "_timeout"}, 32'(bus.ld_timeout_o), 32'd0);
      chk({tag, "_stall"}, 32'(bus.stall_o), 32'd0);
   endtask

   task automatic do_alu(input logic [4:0] rd, input logic we, input logic [31:0] val);
      bus.mem_valid_i    = 1'b1;
      bus.mem_reg_write  = we;
      bus.mem_rd_sel     = 1'b0;
      bus.mem_rd_addr    = rd;
      bus.mem_funct3     = 3'($urandom);
      bus.mem_alu_result = val;
      bus.dm_rvalid      = 1'($urandom);
      bus.dm_rdata       = $urandom;
      chk("alu_stall", 32'(bus.stall_o), 32'd0);
      if (we && rd != 5'd0) expect_ev(K_WR, rd, val);
      @(negedge clk);
   endtask

   task automatic idle_cycle();
      bus.mem_valid_i    = 1'b0;
      bus.mem_reg_write  = 1'($urandom);
      bus.mem_rd_sel     = 1'($urandom);
      bus.mem_rd_addr    = 5'($urandom);
      bus.mem_alu_result = $urandom;
      bus.dm_rvalid      = 1'($urandom);
      bus.dm_rdata       = $urandom;
      @(negedge clk);
   endtask

   // delay: WAIT cycle (1-based) carrying the response; 0 or >LT means never.
   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                          input logic we, input logic [31:0] word, input int delay);
      int  a;
      bit  ok;
      a  = int'(addr[1:0]);
      ok = is_legal(int'(f3)) && !is_mis(int'(f3), a);
      bus.mem_valid_i    = 1'b1;
      bus.mem_reg_write  = we;
      bus.mem_rd_sel     = 1'b1;
      bus.mem_rd_addr    = rd;
      bus.mem_funct3     = f3;
      bus.mem_alu_result = addr;
      bus.dm_rvalid      = 1'($urandom);
      bus.dm_rdata       = $urandom;
      chk("load_issue_stall", 32'(bus.stall_o), 32'd0);
      if (!is_legal(int'(f3)))                       expect_ev(K_ILL, 5'd0, 32'd0);
      else if (is_mis(int'(f3), a))                  expect_ev(K_MIS, 5'd0, 32'd0);
      else if (delay >= 1 && delay <= LT) begin
         if (we && rd != 5'd0) expect_ev(K_WR, rd, ref_load(int'(f3), a, word));
      end else                                       expect_ev(K_TO, 5'd0, 32'd0);
      @(negedge clk);
      if (ok) begin
         for (int w = 1; w <= LT; w++) begin
            chk("wait_stall", 32'(bus.stall_o), 32'd1);
            bus.mem_valid_i    = 1'b1;
            bus.mem_reg_write  = 1'b1;
            bus.mem_rd_sel     = 1'($urandom);
            bus.mem_rd_addr    = 5'($urandom_range(1, 31));
            bus.mem_alu_result = $urandom;
            bus.dm_rvalid      = (w == delay);
            bus.dm_rdata       = (w == delay) ? word : $urandom;
            @(negedge clk);
            if (w == delay) break;
         end
         bus.dm_rvalid   = 1'b0;
         bus.mem_valid_i = 1'b0;
         chk("load_done_stall", 32'(bus.stall_o), 32'd0);
      end else begin
         bus.mem_valid_i = 1'b0;
      end
   endtask

   task automatic reset_mid_load();
      bus.mem_valid_i    = 1'b1;
      bus.mem_reg_write  = 1'b1;
      bus.mem_rd_sel     = 1'b1;
      bus.mem_rd_addr    = 5'd6;
      bus.mem_funct3     = F3_LW;
      bus.mem_alu_result = 32'h0000_3000;
      bus.dm_rvalid      = 1'b0;
      @(negedge clk);
      bus.mem_valid_i = 1'b0;
      @(negedge clk);
      chk("pre_reset_stall", 32'(bus.stall_o), 32'd1);
      #2 rst = 1'b0;
      #1 reset_check("midload_reset");
      @(negedge clk);
      #2 rst = 1'b1;
      bus.dm_rvalid = 1'b1;
      bus.dm_rdata  = 32'h1234_5678;
      @(negedge clk);
      @(negedge clk);
      bus.dm_rvalid = 1'b0;
      chk("post_reset_stall", 32'(bus.stall_o), 32'd0);
      do_alu(5'd14, 1'b1, 32'hCAFE_F00D);
   endtask

   initial begin
      rst = 1'b1;
      bus.mem_valid_i    = 1'b0;
      bus.mem_reg_write  = 1'b0;
      bus.mem_rd_sel     = 1'b0;
      bus.mem_rd_addr    = '0;
      bus.mem_funct3     = '0;
      bus.mem_alu_result = '0;
      bus.dm_rvalid      = 1'b0;
      bus.dm_rdata       = '0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      reset_check("init_reset");
      rst = 1'b1;
      @(negedge clk);

      do_alu(5'd5, 1'b1, 32'hDEAD_BEEF);
      do_alu(5'd7, 1'b1, 32'h0102_0304);
      do_alu(5'd0, 1'b1, 32'hFFFF_FFFF);
      do_alu(5'd9, 1'b0, 32'h5555_AAAA);
      do_load(F3_LB,  32'h0000_1003, 5'd10, 1'b1, 32'h80FF_1234, 3);
      do_load(F3_LBU, 32'h0000_1003, 5'd10, 1'b1, 32'h80FF_1234, 3);
      do_load(F3_LH,  32'h0000_1002, 5'd11, 1'b1, 32'h8001_7FFF, 2);
      do_load(F3_LHU, 32'h0000_1001, 5'd11, 1'b1, 32'h8001_7FFF, 2);
      do_load(F3_LW,  32'h0000_2000, 5'd12, 1'b1, 32'hA5A5_0F0F, 0);
      do_load(F3_LW,  32'h0000_2000, 5'd12, 1'b1, 32'h1357_9BDF, LT);
      do_load(F3_LW,  32'h0000_2004, 5'd0,  1'b1, 32'h7777_7777, 1);
      do_load(3'b011, 32'h0000_2008, 5'd13, 1'b1, 32'h0, 1);
      reset_mid_load();

      for (int i = 0; i < 300; i++) begin
         int op;
         op = $urandom_range(0, 7);
         if (op <= 2)      do_alu(5'($urandom), 1'($urandom_range(0, 3) != 0), $urandom);
         else if (op == 3) idle_cycle();
         else do_load(3'($urandom), $urandom, 5'($urandom), 1'($urandom_range(0, 3) != 0), $urandom,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, LT + 2) : $urandom_range(1, 4));
      end

      bus.mem_valid_i = 1'b0;
      bus.dm_rvalid   = 1'b0;
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
